prog_lut_neuron: RTL and testbench
==================================

# prog_lut_neuron

Run-time programmable truth-table neuron, the writer-side counterpart of the fixed distributed-ROM neuron modules emitted per layer.
- A configuration stream loads a 2^IN_BITS-entry table in address order; after a complete load the block serves registered lookups on a valid/ready inference port.
- It sits where a generated `layerN_NM` module would sit, so retrained tables load without re-synthesis.
- Table index is the concatenated quantised inputs, exactly as the generated neurons use their `M0` bus.

## Interface
- IN_BITS, 8, width of lookup index; table depth is 2^IN_BITS.
- OUT_BITS, 2, width of each table entry and of the lookup result.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_start  in  1  one-cycle pulse; aborts any load and begins a new load at index 0.
- cfg_valid  in  1  cfg beat valid.
- cfg_ready  out  1  high only in LOADING.
- cfg_data  in  OUT_BITS  table entry for the current write index.
- cfg_last  in  1  marks the final beat; must coincide with index 2^IN_BITS-1.
- cfg_err  out  1  sticky load-error flag; cleared by cfg_start or reset.
- loaded  out  1  high in READY.
- in_valid  in  1  lookup request valid.
- in_ready  out  1  equals READY && (!out_valid || out_ready).
- in_data  in  IN_BITS  lookup index.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  OUT_BITS  table[in_data], registered.

## Operation
- States:
  - EMPTY (reset): no valid table.
  - LOADING: accepting cfg beats.
  - READY: table complete, serving lookups.
- Transitions:
  - cfg_start from any state -> LOADING, with wr_idx=0 and cfg_err=0.
  - LOADING, beat with cfg_last and wr_idx==2^IN_BITS-1 -> READY.
  - LOADING, beat with cfg_last and wr_idx<2^IN_BITS-1 (early last) -> EMPTY, cfg_err=1.
  - LOADING, beat at wr_idx==2^IN_BITS-1 without cfg_last (overrun) -> EMPTY, cfg_err=1.
- Write rules:
  - A cfg beat is cfg_valid && cfg_ready. It writes cfg_data to table[wr_idx], then increments wr_idx (IN_BITS wide, no wrap is ever used).
  - The erroring beat is still written; the table contents are don't-care in EMPTY.
- Lookup path:
  - Accepted only when in_valid && in_ready.
  - On accept, out_data is loaded from table[in_data] and out_valid is set.
  - out_valid clears on out_ready when no new accept occurs in the same cycle.
  - Accept and drain in the same cycle is allowed and keeps out_valid=1 (full throughput).
- Entering LOADING forces out_valid=0; an unconsumed result is dropped.
- cfg_start in the same cycle as an accepted lookup: the lookup reads the old table and its result is dropped by the rule above.
- cfg_start while already LOADING restarts at index 0; earlier partial writes are simply overwritten.
- cfg_valid outside LOADING is ignored (cfg_ready=0).
- Reset values:
  - Outputs: cfg_ready=0, cfg_err=0, loaded=0, in_ready=0, out_valid=0, out_data=0.
  - wr_idx=0.
  - Table contents are not reset (distributed RAM).
- Reset asserted mid-load returns to EMPTY immediately; a fresh cfg_start is required.

## Timing
- cfg_start registered: cfg_ready rises the cycle after the pulse.
- Full load takes 2^IN_BITS accepted beats. With continuous cfg_valid, loaded rises 2^IN_BITS+1 cycles after cfg_start.
- Lookup latency is 1 cycle (accept at edge N, out_valid/out_data valid after edge N). Throughput is 1 per cycle when out_ready=1.
- Table write is synchronous and read is asynchronous. A lookup can never coincide with a write because the READY and LOADING states are exclusive.

## Structure
- Package `lut_neuron_pkg`:
  - Constants: IN_BITS default, OUT_BITS default, DEPTH = 1<<IN_BITS.
  - State enum: EMPTY, LOADING, READY.
- Sub-module `lut_dist_ram`: DEPTH x OUT_BITS, one synchronous write port, one asynchronous read port, distributed ROM/RAM style attribute.
- Top module holds the FSM, write counter, error logic and output register.

## Test plan
- Reset, then lookup attempts with in_valid=1 -> in_ready=0, out_valid=0, loaded=0.
- Load table[i] = i[1:0] ^ i[7:6] (256 beats, last on beat 255) -> loaded=1 at cycle 257 after cfg_start. Then in_data=8'hC1 -> out_data=2'b10, and in_data=8'h03 -> 2'b11, each 1 cycle later.
- cfg_last on beat 100 -> cfg_err=1, state EMPTY, in_ready stays 0. A subsequent cfg_start clears cfg_err.
- Beat 255 without cfg_last -> cfg_err=1, loaded=0.
- Back-to-back lookups over all 256 indices with out_ready toggling every other cycle -> every result matches the loaded table, none lost or duplicated.
- cfg_start with a held result (out_ready=0) -> out_valid drops next cycle. Reload with all-zero entries -> lookup 8'hC1 returns 2'b00. Assert rst_n low mid-load -> immediate EMPTY.

Source files
------------

// File: rtl/lut_neuron_pkg.sv
// Shared constants and state encoding for the programmable truth-table neuron.
package lut_neuron_pkg;

  localparam int unsigned DefInBits  = 8;
  localparam int unsigned DefOutBits = 2;
  localparam int unsigned DefDepth   = 1 << DefInBits;

  typedef enum logic [1:0] {
    StEmpty   = 2'd0,
    StLoading = 2'd1,
    StReady   = 2'd2
  } state_e;

endpackage

// File: rtl/lut_dist_ram.sv
// Small truth-table storage: synchronous write, asynchronous read, no reset on contents.
module lut_dist_ram #(
  parameter int unsigned AddrBits = 8,
  parameter int unsigned Width    = 2
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AddrBits-1:0] waddr,
  input  logic [Width-1:0]    wdata,
  input  logic [AddrBits-1:0] raddr,
  output logic [Width-1:0]    rdata
);

  localparam int unsigned Depth = 1 << AddrBits;

  (* ram_style = "distributed" *) logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_lut_neuron.sv
// Run-time loadable truth-table neuron: cfg stream fills the table in index order,
// then registered lookups are served on a valid/ready port.
module prog_lut_neuron
  import lut_neuron_pkg::*;
#(
  parameter int unsigned IN_BITS  = DefInBits,
  parameter int unsigned OUT_BITS = DefOutBits
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [OUT_BITS-1:0] cfg_data,
  input  logic                cfg_last,
  output logic                cfg_err,
  output logic                loaded,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_BITS-1:0]  in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_BITS-1:0] out_data
);

  state_e               state_q, state_d;
  logic [IN_BITS-1:0]   wr_idx_q, wr_idx_d;
  logic                 cfg_err_q, cfg_err_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_BITS-1:0]  out_data_q, out_data_d;
  logic [OUT_BITS-1:0]  rd_data;
  logic                 cfg_beat, accept, last_idx, tbl_we;

  assign cfg_ready = (state_q == StLoading);
  assign loaded    = (state_q == StReady);
  assign in_ready  = loaded && (!out_valid_q || out_ready);
  assign cfg_beat  = cfg_valid && cfg_ready;
  assign accept    = in_valid && in_ready;
  assign last_idx  = &wr_idx_q;
  // A restart pulse wins over a coincident beat; that beat belongs to the aborted load.
  assign tbl_we    = cfg_beat && !cfg_start;

  lut_dist_ram #(
    .AddrBits (IN_BITS),
    .Width    (OUT_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (tbl_we),
    .waddr (wr_idx_q),
    .wdata (cfg_data),
    .raddr (in_data),
    .rdata (rd_data)
  );

  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    cfg_err_d = cfg_err_q;
    if (cfg_start) begin
      state_d   = StLoading;
      wr_idx_d  = '0;
      cfg_err_d = 1'b0;
    end else if (cfg_beat) begin
      wr_idx_d = wr_idx_q + 1'b1;
      if (cfg_last && last_idx) begin
        state_d = StReady;
      end else if (cfg_last || last_idx) begin
        // Early last or overrun: the table is unusable.
        state_d   = StEmpty;
        cfg_err_d = 1'b1;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (accept) begin
      out_data_d = rd_data;
    end
    if (cfg_start) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      wr_idx_q    <= '0;
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      cfg_err_q   <= cfg_err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign cfg_err   = cfg_err_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_prog_lut_neuron.sv
// Directed bench for prog_lut_neuron: load, error paths, streaming lookups, restart and reset.
module tb_prog_lut_neuron;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_start, cfg_valid, cfg_ready, cfg_last, cfg_err, loaded;
  logic [1:0] cfg_data;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data;
  logic [1:0] out_data;

  int tests = 0;
  int fails = 0;

  prog_lut_neuron #(
    .IN_BITS  (8),
    .OUT_BITS (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_last  (cfg_last),
    .cfg_err   (cfg_err),
    .loaded    (loaded),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // mode 0: i[1:0] ^ i[7:6]; mode 1: all zero
  function automatic logic [1:0] val(input int mode, input int i);
    logic [7:0] b;
    b = i[7:0];
    return (mode == 0) ? (b[1:0] ^ b[7:6]) : 2'b00;
  endfunction

  // Stimulus only: pulse cfg_start then stream n_beats, cfg_last on beat last_beat.
  // lat = edges from cfg_start capture until loaded first seen (-1 if never).
  task automatic do_load(input int mode, input int last_beat, input int n_beats,
                         output int lat, output int beats);
    int  edges;
    logic took;
    lat = -1; beats = 0;
    @(negedge clk);
    cfg_start = 1'b1; cfg_valid = 1'b0; cfg_last = 1'b0;
    @(negedge clk);
    cfg_start = 1'b0; edges = 1;
    while (beats < n_beats && edges < 1000) begin
      cfg_valid = 1'b1;
      cfg_data  = val(mode, beats);
      cfg_last  = (beats == last_beat);
      took      = cfg_ready;
      @(negedge clk);
      edges++;
      if (took) beats++;
      if (loaded && lat < 0) lat = edges;
    end
    cfg_valid = 1'b0; cfg_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h12;
    repeat (2) @(negedge clk);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    tests++; if (loaded !== 1'b0) begin fails++; $display("FAIL rst_loaded: got %b want 0", loaded); end
    tests++; if (cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
      fails++; $display("FAIL rst_cfg: got ready=%b err=%b want 0 0", cfg_ready, cfg_err);
    end
    tests++; if (out_data !== 2'b00) begin fails++; $display("FAIL rst_out_data: got %b want 00", out_data); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || loaded !== 1'b0) begin
      fails++; $display("FAIL empty_lookup: got in_ready=%b out_valid=%b loaded=%b want 0 0 0",
                        in_ready, out_valid, loaded);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_load_lookup();
    int lat, beats;
    do_load(0, 255, 256, lat, beats);
    tests++; if (beats != 256) begin fails++; $display("FAIL load_beats: got %0d want 256", beats); end
    tests++; if (lat != 257) begin fails++; $display("FAIL load_latency: got %0d want 257", lat); end
    tests++; if (loaded !== 1'b1 || cfg_err !== 1'b0 || cfg_ready !== 1'b0) begin
      fails++; $display("FAIL load_done: got loaded=%b err=%b ready=%b want 1 0 0",
                        loaded, cfg_err, cfg_ready);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hC1;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ready_in: got %b want 1", in_ready); end
    @(negedge clk);
    in_data = 8'h03;
    tests++; if (out_valid !== 1'b1 || out_data !== 2'b10) begin
      fails++; $display("FAIL lookup_c1: got v=%b d=%b want 1 10", out_valid, out_data);
    end
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_data !== 2'b11) begin
      fails++; $display("FAIL lookup_03: got v=%b d=%b want 1 11", out_valid, out_data);
    end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain: got %b want 0", out_valid); end
    // Stray cfg beats in READY must be ignored.
    cfg_valid = 1'b1; cfg_last = 1'b1;
    repeat (2) @(negedge clk);
    cfg_valid = 1'b0; cfg_last = 1'b0;
    tests++; if (loaded !== 1'b1 || cfg_err !== 1'b0) begin
      fails++; $display("FAIL cfg_ignored: got loaded=%b err=%b want 1 0", loaded, cfg_err);
    end
  endtask

  task automatic test_early_last();
    int lat, beats;
    do_load(0, 100, 101, lat, beats);
    in_valid = 1'b1; in_data = 8'h00;
    #1;
    tests++; if (cfg_err !== 1'b1 || loaded !== 1'b0 || cfg_ready !== 1'b0) begin
      fails++; $display("FAIL early_last: got err=%b loaded=%b ready=%b want 1 0 0",
                        cfg_err, loaded, cfg_ready);
    end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL early_in_ready: got %b want 0", in_ready); end
    in_valid = 1'b0;
    @(negedge clk); cfg_start = 1'b1;
    @(negedge clk); cfg_start = 1'b0;
    tests++; if (cfg_err !== 1'b0 || cfg_ready !== 1'b1) begin
      fails++; $display("FAIL err_clear: got err=%b ready=%b want 0 1", cfg_err, cfg_ready);
    end
  endtask

  task automatic test_overrun();
    int lat, beats;
    do_load(0, -1, 256, lat, beats);
    tests++; if (cfg_err !== 1'b1 || loaded !== 1'b0) begin
      fails++; $display("FAIL overrun: got err=%b loaded=%b want 1 0", cfg_err, loaded);
    end
  endtask

  task automatic test_back_to_back();
    int lat, beats, idx, got, cyc;
    logic [1:0] q[$];
    logic [1:0] exp_v;
    do_load(0, 255, 256, lat, beats);
    tests++; if (loaded !== 1'b1) begin fails++; $display("FAIL b2b_loaded: got %b want 1", loaded); end
    idx = 0; got = 0; cyc = 0;
    while (got < 256 && cyc < 2000) begin
      @(negedge clk);
      out_ready = cyc[0];
      in_valid  = (idx < 256);
      in_data   = idx[7:0];
      #1;
      if (out_valid && out_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++; $display("FAIL b2b_dup: got extra result %b want none", out_data);
        end else begin
          exp_v = q.pop_front();
          if (out_data !== exp_v) begin
            fails++; $display("FAIL b2b_data[%0d]: got %b want %b", got, out_data, exp_v);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(val(0, idx));
        idx++;
      end
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tests++; if (got != 256 || idx != 256) begin
      fails++; $display("FAIL b2b_count: got %0d sent %0d want 256", got, idx);
    end
    @(negedge clk);
    tests++; if (q.size() != 0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL b2b_tail: got left=%0d v=%b want 0 0", q.size(), out_valid);
    end
  endtask

  task automatic test_start_drop();
    int lat, beats;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hC1;
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_data !== 2'b10) begin
      fails++; $display("FAIL held: got v=%b d=%b want 1 10", out_valid, out_data);
    end
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    tests++; if (out_valid !== 1'b0 || loaded !== 1'b0 || cfg_ready !== 1'b1) begin
      fails++; $display("FAIL start_drop: got v=%b loaded=%b ready=%b want 0 0 1",
                        out_valid, loaded, cfg_ready);
    end
    out_ready = 1'b1;
    do_load(1, 255, 256, lat, beats);
    tests++; if (loaded !== 1'b1) begin fails++; $display("FAIL zero_load: got %b want 1", loaded); end
    in_valid = 1'b1; in_data = 8'hC1;
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b1 || out_data !== 2'b00) begin
      fails++; $display("FAIL zero_c1: got v=%b d=%b want 1 00", out_valid, out_data);
    end
  endtask

  task automatic test_reset_mid_load();
    int lat, beats;
    do_load(0, -1, 50, lat, beats);
    tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL midload: got %b want 1", cfg_ready); end
    cfg_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    tests++; if (cfg_ready !== 1'b0 || loaded !== 1'b0 || cfg_err !== 1'b0) begin
      fails++; $display("FAIL async_rst: got ready=%b loaded=%b err=%b want 0 0 0",
                        cfg_ready, loaded, cfg_err);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (cfg_ready !== 1'b0 || loaded !== 1'b0) begin
      fails++; $display("FAIL post_rst: got ready=%b loaded=%b want 0 0", cfg_ready, loaded);
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_last = 1'b0; cfg_data = 2'b00;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    test_reset();
    test_load_lookup();
    test_early_last();
    test_overrun();
    test_back_to_back();
    test_start_drop();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
